axi_stream_arbiter: RTL and testbench
=====================================

Name: axi_stream_arbiter

Overview:
Packet-granular round-robin arbiter that shares one AXI-Stream slave port between NUM_SRC AXI-Stream masters. A grant lasts for a whole packet and is released on the tlast handshake. Data comes from axi_stream_pkg::data_t. The arbiter sits upstream of axi_stream_slave, whose receive buffer holds 8 beats.

Parameters:
NUM_SRC, 4, number of requesting stream sources (legal range 2..16)
MAX_PKT_LEN, 8, maximum beats per packet accepted downstream (used only by the optional length guard)

Ports:
aclk  input  1  clock; all logic is on the rising edge
areset  input  1  reset, asynchronous and active-high
s_tvalid  input  NUM_SRC  per-source tvalid
s_tready  output  NUM_SRC  per-source tready
s_tdata  input  data_t[NUM_SRC]  per-source tdata
s_tlast  input  NUM_SRC  per-source tlast
m_tvalid  output  1  downstream tvalid
m_tready  input  1  downstream tready
m_tdata  output  data_t  downstream tdata
m_tlast  output  1  downstream tlast
grant_valid  output  1  high while a packet is granted (state BUSY)
grant_idx  output  $clog2(NUM_SRC)  index of the current or most recent granted source
len_err  output  1  one-cycle pulse for a length violation (0 unless AXIS_ARB_LEN_CHECK_EN is defined)

Behaviour:
- Reset (asynchronous, effective immediately):
  - state=IDLE, grant_idx=0, last_grant=NUM_SRC-1 (so source 0 wins first).
  - m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, grant_valid=0, len_err=0.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - m_tvalid=0 and all s_tready=0.
  - If any s_tvalid is high, pick the first asserted index searching upward from last_grant+1, wrapping modulo NUM_SRC.
  - Register that index into grant_idx and move to BUSY on the next edge.
  - If no s_tvalid is high, stay in IDLE.
- BUSY:
  - m_tvalid = s_tvalid[grant_idx], m_tdata = s_tdata[grant_idx], m_tlast = s_tlast[grant_idx]. These are combinational muxes with no added latency.
  - s_tready[grant_idx] = m_tready; every other s_tready is 0.
  - A handshake is m_tvalid && m_tready.
  - On a handshake with m_tlast=1: last_grant <= grant_idx and the FSM returns to IDLE.
- Latency:
  - The request-to-first-beat bubble is one cycle (the IDLE arbitration cycle).
  - Back-to-back packets always pass through one IDLE cycle.
- Fairness: a source just served has the lowest priority in the next arbitration. With all sources requesting, the grant order is 0,1,2,3,0,...
- Boundary conditions:
  - Granted source drops tvalid mid-packet: the grant is held indefinitely. There is no timeout and no re-arbitration before tlast.
  - m_tready held low: beats stall; m_tvalid/m_tdata/m_tlast follow the granted source unchanged.
  - Single-beat packet (tlast on the first beat): legal; the FSM is back in IDLE after one BUSY cycle.
  - Non-granted sources never see s_tready high; their beats are never accepted or dropped.
  - Only one source requesting: it is granted regardless of last_grant.
  - Reset asserted mid-packet: the FSM is in IDLE immediately and outputs drop the same cycle. The partial packet is abandoned; the source must restart after reset.
- Beat counter: width $clog2(MAX_PKT_LEN)+1. Cleared on entry to BUSY; increments on each handshake. Exists only when the optional feature is enabled.

Optional Feature:
Macro: AXIS_ARB_LEN_CHECK_EN
- Defined:
  - On the MAX_PKT_LEN-th handshake of a packet, if the source's tlast is 0, m_tlast is forced to 1.
  - The grant is released (FSM returns to IDLE) and len_err pulses high for that one cycle.
  - Any remaining beats from that source are arbitrated later as a new packet.
  - This protects the 8-entry downstream buffer.
- Not defined: no beat counter exists, len_err is tied to 0, and packets of any length pass unchanged.

Test Plan:
- Reset, then source 2 sends 3 beats (0xA,0xB,0xC; tlast on 0xC), m_tready=1 -> grant_idx=2, m_tvalid high starting 1 cycle after s_tvalid rises, m_tlast on 0xC, FSM in IDLE the next cycle.
- All 4 sources hold 2-beat packets continuously -> grant order 0,1,2,3,0; exactly one IDLE cycle between packets; no s_tready on a non-granted source.
- Source 1 granted; its tvalid drops for 3 cycles mid-packet while source 3 requests -> grant_idx stays 1; source 3 served only after source 1's tlast.
- m_tready toggles 1,0,0,1 during a 4-beat packet from source 0 -> m_tdata/m_tlast stable while stalled; 4 handshakes total; s_tready[0] mirrors m_tready.
- Reset asserted during beat 2 of a 5-beat packet -> m_tvalid=0, s_tready=0 and grant_valid=0 in the same cycle; after release, source 0 has top priority.
- With AXIS_ARB_LEN_CHECK_EN defined, source 1 sends 10 beats with no tlast -> m_tlast forced on beat 8, len_err pulses once; beats 9-10 form a new packet with their own grant.

Source files
------------

// File: rtl/axi_stream_arbiter.sv
// Packet-granular round-robin arbiter: NUM_SRC AXI-Stream masters share one downstream port; 1-cycle arbitration bubble, data path is combinational.
// Backpressure: m_tready is routed only to the granted source; AXIS_ARB_LEN_CHECK_EN enables the MAX_PKT_LEN length guard.
package axi_stream_pkg;
    parameter int DATA_W = 32;
    typedef logic [DATA_W-1:0] data_t;
endpackage

module axi_stream_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int MAX_PKT_LEN = 8
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic [NUM_SRC-1:0]                   s_tvalid,
    output logic [NUM_SRC-1:0]                   s_tready,
    input  axi_stream_pkg::data_t [NUM_SRC-1:0]  s_tdata,
    input  logic [NUM_SRC-1:0]                   s_tlast,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output axi_stream_pkg::data_t                m_tdata,
    output logic                                 m_tlast,
    output logic                                 grant_valid,
    output logic [$clog2(NUM_SRC)-1:0]           grant_idx,
    output logic                                 len_err
);
    localparam int IDX_W = $clog2(NUM_SRC);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_last_nxt;
    logic [IDX_W-1:0]   w_pick;
    logic               w_hs;

    if (NUM_SRC < 2 || NUM_SRC > 16 || MAX_PKT_LEN < 1) begin : g_bad_cfg
        $error("axi_stream_arbiter: unsupported NUM_SRC or MAX_PKT_LEN");
    end

    function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base, input int off);
        int v;
        v = int'(base) + off;
        if (v >= NUM_SRC) v -= NUM_SRC;
        return IDX_W'(v);
    endfunction

    // Scan from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin : p_rr_pick
        w_pick = r_last_grant;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (s_tvalid[f_wrap(r_last_grant, k)]) w_pick = f_wrap(r_last_grant, k);
        end
    end

`ifdef AXIS_ARB_LEN_CHECK_EN
    localparam int CNT_W = $clog2(MAX_PKT_LEN) + 1;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             w_len_hit;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_beat_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_beat_cnt <= '0;
        end else if (w_hs) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_grant_idx  <= '0;
            r_last_grant <= IDX_W'(NUM_SRC - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant_idx  <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    always_comb begin : p_fsm
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_idx;
        w_last_nxt  = r_last_grant;
        m_tvalid    = 1'b0;
        m_tdata     = '0;
        m_tlast     = 1'b0;
        s_tready    = '0;
        w_hs        = 1'b0;
        len_err     = 1'b0;
`ifdef AXIS_ARB_LEN_CHECK_EN
        w_len_hit   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|s_tvalid) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                m_tvalid              = s_tvalid[r_grant_idx];
                m_tdata               = s_tdata[r_grant_idx];
                s_tready[r_grant_idx] = m_tready;
`ifdef AXIS_ARB_LEN_CHECK_EN
                // Cut an over-long packet so the downstream buffer never overflows.
                w_len_hit = (r_beat_cnt == CNT_W'(MAX_PKT_LEN - 1)) && !s_tlast[r_grant_idx];
                m_tlast   = s_tlast[r_grant_idx] | w_len_hit;
`else
                m_tlast   = s_tlast[r_grant_idx];
`endif
                w_hs = m_tvalid && m_tready;
`ifdef AXIS_ARB_LEN_CHECK_EN
                len_err = w_hs && w_len_hit;
`endif
                if (w_hs && m_tlast) begin
                    w_last_nxt  = r_grant_idx;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign grant_valid = (r_state == ST_BUSY);
    assign grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_axi_stream_arbiter.sv
// Scoreboard bench for axi_stream_arbiter: randomized per-source packet traffic against a round-robin packet model.
module tb_axi_stream_arbiter;
    import axi_stream_pkg::*;

    localparam int NS   = 4;
    localparam int MAXL = 8;

    logic               aclk = 1'b0;
    logic               areset = 1'b0;
    logic [NS-1:0]      s_tvalid, s_tready, s_tlast;
    data_t [NS-1:0]     s_tdata;
    logic               m_tvalid, m_tready, m_tlast, grant_valid, len_err;
    data_t              m_tdata;
    logic [1:0]         grant_idx;

    axi_stream_arbiter #(.NUM_SRC(NS), .MAX_PKT_LEN(MAXL)) dut (
        .aclk(aclk), .areset(areset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .len_err(len_err)
    );

    always #5 aclk = ~aclk;

    typedef struct packed { data_t d; logic l; } beat_t;

    beat_t       pend_q [NS][$];
    beat_t       exp_q  [NS][$];
    int          grant_log [$];
    int unsigned vld_pct [NS];
    int unsigned rdy_pct;
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;

    bit          mdl_busy;
    int          mdl_grant;
    int          mdl_last;
    int          mdl_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pkt(input int src, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = data_t'($urandom);
            b.l = (i == len - 1);
            pend_q[src].push_back(b);
        end
    endtask

    // Source and sink driver: beats are held until accepted; gaps only between beats.
    initial begin : p_driver
        logic [NS-1:0] acc;
        beat_t b;
        forever begin
            @(negedge aclk);
            acc = s_tvalid & s_tready;
            @(posedge aclk);
            #1;
            if (areset) begin
                s_tvalid = '0;
            end else begin
                for (int s = 0; s < NS; s++) begin
                    if (!(s_tvalid[s] && !acc[s])) begin
                        s_tvalid[s] = 1'b0;
                        if (pend_q[s].size() > 0 && $urandom_range(99) < vld_pct[s]) begin
                            b = pend_q[s].pop_front();
                            s_tdata[s]  = b.d;
                            s_tlast[s]  = b.l;
                            s_tvalid[s] = 1'b1;
                            exp_q[s].push_back(b);
                        end
                    end
                end
            end
            m_tready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Monitor: packet-level round-robin model, compared every cycle.
    initial begin : p_monitor
        logic [NS-1:0] er;
        beat_t b;
        bit hit, exp_last;
        forever begin
            @(negedge aclk);
            if (areset) begin
                mdl_busy = 0; mdl_grant = 0; mdl_last = NS - 1; mdl_cnt = 0;
            end else begin
                chk("grant_valid", 64'(grant_valid), 64'(mdl_busy));
                if (mdl_busy) chk("grant_idx", 64'(grant_idx), 64'(mdl_grant));
                if (!mdl_busy) begin
                    chk("idle_m_tvalid", 64'(m_tvalid), 64'd0);
                    chk("idle_s_tready", 64'(s_tready), 64'd0);
                    if (|s_tvalid) begin
                        for (int k = NS; k >= 1; k--)
                            if (s_tvalid[(mdl_last + k) % NS]) mdl_grant = (mdl_last + k) % NS;
                        mdl_busy = 1;
                        mdl_cnt  = 0;
                        grant_log.push_back(mdl_grant);
                    end
                end else begin
                    er = '0;
                    if (m_tready) er[mdl_grant] = 1'b1;
                    chk("s_tready", 64'(s_tready), 64'(er));
                    chk("m_tvalid", 64'(m_tvalid), 64'(s_tvalid[mdl_grant]));
                    if (m_tvalid) begin
                        if (exp_q[mdl_grant].size() == 0) begin
                            chk("beat_expected", 64'd0, 64'd1);
                        end else begin
                            b = exp_q[mdl_grant][0];
                            chk("m_tdata", 64'(m_tdata), 64'(b.d));
`ifdef AXIS_ARB_LEN_CHECK_EN
                            hit = (mdl_cnt == MAXL - 1) && !b.l;
`else
                            hit = 0;
`endif
                            exp_last = b.l | hit;
                            chk("m_tlast", 64'(m_tlast), 64'(exp_last));
                            chk("len_err", 64'(len_err), 64'(hit && m_tready));
                            if (m_tready) begin
                                void'(exp_q[mdl_grant].pop_front());
                                hs_count++;
                                mdl_cnt++;
                                if (exp_last) begin
                                    mdl_busy = 0;
                                    mdl_last = mdl_grant;
                                end
                            end
                        end
                    end else begin
                        chk("len_err_idle", 64'(len_err), 64'd0);
                    end
                end
            end
        end
    end

    task automatic do_reset(input bit check_grant_idx);
        @(posedge aclk);
        #3;
        areset = 1'b1;
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_grant_valid", 64'(grant_valid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_len_err", 64'(len_err), 64'd0);
        if (check_grant_idx) chk("rst_grant_idx", 64'(grant_idx), 64'd0);
        for (int s = 0; s < NS; s++) begin
            pend_q[s].delete();
            exp_q[s].delete();
        end
        s_tvalid = '0;
        repeat (2) @(posedge aclk);
        #3;
        areset = 1'b0;
        grant_log.delete();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            @(negedge aclk);
            #1;
            n++;
            done = !mdl_busy;
            for (int s = 0; s < NS; s++)
                if (pend_q[s].size() != 0 || exp_q[s].size() != 0) done = 0;
        end
        if (!done) chk("drain_timeout", 64'(n), 64'(budget + 1));
    endtask

    task automatic chk_log(input string name, input int exp [$]);
        chk({name, "_len"}, 64'(grant_log.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
            chk(name, 64'(grant_log[i]), 64'(exp[i]));
    endtask

    initial begin : p_main
        int n;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
        rdy_pct = 100;
        for (int s = 0; s < NS; s++) vld_pct[s] = 100;

        // Single 3-beat packet from source 2.
        do_reset(1'b1);
        pend_q[2].push_back('{d: data_t'(32'hA), l: 1'b0});
        pend_q[2].push_back('{d: data_t'(32'hB), l: 1'b0});
        pend_q[2].push_back('{d: data_t'(32'hC), l: 1'b1});
        wait_drain(100);
        chk_log("grant_src2", '{2});

        // All sources continuously requesting 2-beat packets.
        do_reset(1'b0);
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < NS; s++) push_pkt(s, 2);
        wait_drain(500);
        chk_log("rr_order", '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3});

        // Granted source with gaps; another source requests meanwhile.
        do_reset(1'b0);
        vld_pct[1] = 30;
        push_pkt(1, 6);
        n = 0;
        while (!grant_valid && n < 200) begin @(negedge aclk); n++; end
        push_pkt(3, 2);
        wait_drain(1000);
        chk_log("hold_grant", '{1, 3});
        vld_pct[1] = 100;

        // Downstream stalls during a 4-beat packet.
        rdy_pct = 50;
        push_pkt(0, 4);
        wait_drain(1000);
        rdy_pct = 100;

        // Reset in the middle of a 5-beat packet.
        do_reset(1'b0);
        push_pkt(0, 5);
        n = 0;
        while (hs_count == 0 && n < 200) begin @(negedge aclk); n++; end
        hs_count = 0;
        rdy_pct = 0;
        do_reset(1'b1);
        rdy_pct = 100;
        push_pkt(3, 2);
        push_pkt(0, 2);
        wait_drain(200);
        chk_log("post_rst_prio", '{0, 3});

        // Over-long packet from source 1.
        do_reset(1'b0);
        push_pkt(1, 10);
        wait_drain(500);
`ifdef AXIS_ARB_LEN_CHECK_EN
        chk_log("long_pkt", '{1, 1});
`else
        chk_log("long_pkt", '{1});
`endif

        // Randomized traffic.
        do_reset(1'b0);
        rdy_pct = 70;
        for (int s = 0; s < NS; s++) begin
            vld_pct[s] = 30 + $urandom_range(70);
            for (int p = 0; p < 6; p++) push_pkt(s, 1 + $urandom_range(11));
        end
        wait_drain(20000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
